// File: rtl/aud_pkg.sv
// Shared definitions for the audio record/playback path: widths, state and mode
// encodings, and the speed-factor clamp used by the recorder, DSP and player.
package aud_pkg;

    localparam int ADDR_W    = 20;
    localparam int DATA_W    = 16;
    localparam int MAX_SPEED = 8;

    localparam logic [3:0] MAX_SPEED_N = 4'(MAX_SPEED);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_FETCH0 = 3'd2,
        ST_FETCH1 = 3'd3,
        ST_CALC   = 3'd4,
        ST_HOLD   = 3'd5,
        ST_PAUSE  = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        MODE_NORMAL = 2'd0,
        MODE_FAST   = 2'd1,
        MODE_SLOW0  = 2'd2,
        MODE_SLOW1  = 2'd3
    } mode_t;

    // Where CALC takes cur/nxt from: held registers, or the SRAM bus just fetched.
    typedef enum logic [1:0] {
        SRC_REGS = 2'd0,
        SRC_F0   = 2'd1,
        SRC_F1   = 2'd2
    } src_t;

    function automatic logic [3:0] clamp_speed(input logic [3:0] s);
        if (s == 4'd0) begin
            return 4'd1;
        end
        if (s > MAX_SPEED_N) begin
            return MAX_SPEED_N;
        end
        return s;
    endfunction

endpackage

// File: rtl/aud_interp.sv
// Combinational linear interpolator: out = cur + ((nxt - cur) * k) / n,
// with the division truncating toward zero.
module aud_interp
    import aud_pkg::*;
(
    input  logic [DATA_W-1:0] cur,
    input  logic [DATA_W-1:0] nxt,
    input  logic [2:0]        k,
    input  logic [3:0]        n,
    output logic [DATA_W-1:0] out
);

    localparam int PROD_W = DATA_W + 4;

    logic signed [DATA_W:0]   diff;
    logic signed [PROD_W-1:0] diff_w;
    logic signed [PROD_W-1:0] k_w;
    logic signed [PROD_W-1:0] n_w;
    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] quot;

    // |diff| * k stays below 2^19 for k <= 7, so the product never overflows.
    always_comb begin
        diff   = {nxt[DATA_W-1], nxt} - {cur[DATA_W-1], cur};
        diff_w = {{(PROD_W-DATA_W-1){diff[DATA_W]}}, diff};
        k_w    = {{(PROD_W-3){1'b0}}, k};
        n_w    = (n == 4'd0) ? {{(PROD_W-1){1'b0}}, 1'b1} : {{(PROD_W-4){1'b0}}, n};
        prod   = diff_w * k_w;
        quot   = prod / n_w;
        out    = cur + quot[DATA_W-1:0];
    end

endmodule

// File: rtl/aud_dsp.sv
// Playback sample processor: walks the recorded SRAM image, applies fast/slow
// speed control and presents one sample per DAC LR-clock period to the player.
module aud_dsp
    import aud_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_daclrck,
    input  logic              i_start,
    input  logic              i_pause,
    input  logic              i_stop,
    input  logic              i_fast,
    input  logic              i_slow_0,
    input  logic              i_slow_1,
    input  logic [3:0]        i_speed,
    input  logic [ADDR_W-1:0] i_end_addr,
    input  logic [DATA_W-1:0] i_sram_data,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic [DATA_W-1:0] o_dac_data,
    output logic              o_player_en,
    output logic              o_busy,
    output logic              o_done,
    output logic [2:0]        o_state
);

    // Player contract: while o_player_en is high, o_dac_data is the sample for the
    // current period; it changes only during the lrc-high half, never while low.
    state_t              state_q, state_d;
    mode_t               mode_q, mode_d, mode_in;
    src_t                src_q, src_d;
    logic                lrc_q;
    logic [ADDR_W-1:0]   a_q, a_d;
    logic [2:0]          k_q, k_d;
    logic [3:0]          n_q, n_d, n_in;
    logic [DATA_W-1:0]   cur_q, cur_d, nxt_q, nxt_d;
    logic [DATA_W-1:0]   dac_q, dac_d;
    logic                en_q, en_d;
    logic                done_q, done_d;

    logic                lrc_rise;
    logic                cfg_change;
    logic                at_end;
    logic [DATA_W-1:0]   cur_eff, nxt_eff, interp_out;
    logic [ADDR_W:0]     adv_a;
    logic [2:0]          adv_k;
    logic                refetch;
    logic                past_end;

    assign lrc_rise = i_daclrck & ~lrc_q;
    assign at_end   = (a_q == i_end_addr);

    always_comb begin
        if (i_fast) begin
            mode_in = MODE_FAST;
        end else if (i_slow_1) begin
            mode_in = MODE_SLOW1;
        end else if (i_slow_0) begin
            mode_in = MODE_SLOW0;
        end else begin
            mode_in = MODE_NORMAL;
        end
        n_in       = (mode_in == MODE_NORMAL) ? 4'd1 : clamp_speed(i_speed);
        cfg_change = (mode_in != mode_q) || (n_in != n_q);
    end

    // Freshly fetched words are used straight off the bus in CALC to save a cycle.
    always_comb begin
        cur_eff = (src_q == SRC_F0) ? i_sram_data : cur_q;
        if (src_q == SRC_F1) begin
            nxt_eff = at_end ? cur_q : i_sram_data;
        end else begin
            nxt_eff = nxt_q;
        end
    end

    aud_interp u_interp (
        .cur (cur_eff),
        .nxt (nxt_eff),
        .k   (k_q),
        .n   (n_q),
        .out (interp_out)
    );

    // Position step taken at the lrc rise that ends a HOLD period.
    always_comb begin
        adv_a   = {1'b0, a_q};
        adv_k   = k_q;
        refetch = 1'b1;
        if (mode_q == MODE_SLOW0 || mode_q == MODE_SLOW1) begin
            if ({1'b0, k_q} < (n_q - 4'd1)) begin
                adv_k   = k_q + 3'd1;
                refetch = 1'b0;
            end else begin
                adv_k = 3'd0;
                adv_a = {1'b0, a_q} + (ADDR_W+1)'(1);
            end
        end else begin
            adv_a = {1'b0, a_q} + {{(ADDR_W-3){1'b0}}, n_q};
        end
        if (cfg_change) begin
            adv_k   = 3'd0;
            refetch = 1'b1;
        end
        past_end = (adv_a > {1'b0, i_end_addr});
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        n_d     = n_q;
        src_d   = src_q;
        a_d     = a_q;
        k_d     = k_q;
        cur_d   = cur_q;
        nxt_d   = nxt_q;
        dac_d   = dac_q;
        en_d    = en_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                a_d   = '0;
                k_d   = '0;
                en_d  = 1'b0;
                dac_d = '0;
                if (i_start) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (lrc_rise) begin
                    mode_d = mode_in;
                    n_d    = n_in;
                    if (cfg_change) begin
                        k_d = '0;
                    end
                    state_d = ST_FETCH0;
                end
            end
            ST_FETCH0: begin
                if (mode_q == MODE_SLOW1) begin
                    src_d   = SRC_F1;
                    state_d = ST_FETCH1;
                end else begin
                    src_d   = SRC_F0;
                    state_d = ST_CALC;
                end
            end
            ST_FETCH1: begin
                cur_d   = i_sram_data;
                state_d = ST_CALC;
            end
            ST_CALC: begin
                cur_d   = cur_eff;
                nxt_d   = nxt_eff;
                dac_d   = (mode_q == MODE_SLOW1) ? interp_out : cur_eff;
                en_d    = 1'b1;
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (lrc_rise) begin
                    mode_d = mode_in;
                    n_d    = n_in;
                    if (past_end) begin
                        a_d     = '0;
                        k_d     = '0;
                        en_d    = 1'b0;
                        dac_d   = '0;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        a_d     = adv_a[ADDR_W-1:0];
                        k_d     = adv_k;
                        src_d   = SRC_REGS;
                        state_d = refetch ? ST_FETCH0 : ST_CALC;
                    end
                end
            end
            ST_PAUSE: begin
                en_d  = 1'b0;
                dac_d = '0;
                if (i_start) begin
                    state_d = ST_WAIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Stop beats pause; both override whatever the state itself decided.
        if (state_q != ST_IDLE) begin
            if (i_stop) begin
                a_d     = '0;
                k_d     = '0;
                en_d    = 1'b0;
                dac_d   = '0;
                done_d  = 1'b0;
                state_d = ST_IDLE;
            end else if (i_pause && state_q != ST_PAUSE) begin
                a_d     = a_q;
                k_d     = k_q;
                mode_d  = mode_q;
                n_d     = n_q;
                en_d    = 1'b0;
                dac_d   = '0;
                done_d  = 1'b0;
                state_d = ST_PAUSE;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lrc_q  <= 1'b0;
            mode_q <= MODE_NORMAL;
            n_q    <= 4'd1;
            src_q  <= SRC_REGS;
            a_q    <= '0;
            k_q    <= '0;
            cur_q  <= '0;
            nxt_q  <= '0;
            dac_q  <= '0;
            en_q   <= 1'b0;
            done_q <= 1'b0;
        end else begin
            lrc_q  <= i_daclrck;
            mode_q <= mode_d;
            n_q    <= n_d;
            src_q  <= src_d;
            a_q    <= a_d;
            k_q    <= k_d;
            cur_q  <= cur_d;
            nxt_q  <= nxt_d;
            dac_q  <= dac_d;
            en_q   <= en_d;
            done_q <= done_d;
        end
    end

    always_comb begin
        o_sram_addr = (state_q == ST_FETCH1 && !at_end) ? (a_q + ADDR_W'(1)) : a_q;
        o_dac_data  = dac_q;
        o_player_en = en_q;
        o_busy      = (state_q != ST_IDLE);
        o_done      = done_q;
        o_state     = state_q;
    end

endmodule
